// File: rtl/qr_pkg.sv
// Shared definitions for the QR image workers: FSM encodings, luma weights and pixel layout.
package qr_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_RD   = 3'd1;
    localparam state_t ST_WT   = 3'd2;
    localparam state_t ST_CMP  = 3'd3;
    localparam state_t ST_WR   = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    localparam int LUMA_R        = 77;
    localparam int LUMA_G        = 150;
    localparam int LUMA_B        = 29;
    localparam int LUMA_SHIFT    = 8;
    localparam int BYTES_PER_PIX = 3;

    // One entry of the read-capture shift line: which channel returns on doutb
    typedef struct packed {
        logic       vld;
        logic [1:0] idx;
    } cap_t;

endpackage

// File: rtl/binarize_w1_if.sv
// Frame-RAM port-b bundle between the W1 worker (master) and solve_img's registered mux (slave).
interface binarize_w1_if #(
    parameter int ADDR_WIDTH = 18
);
    logic                  web_w1;
    logic [ADDR_WIDTH-1:0] addrb_w1;
    logic [7:0]            dinb_w1;
    logic [7:0]            doutb;

    modport master (output web_w1, addrb_w1, dinb_w1, input doutb);
    modport slave  (input web_w1, addrb_w1, dinb_w1, output doutb);
endinterface

// File: rtl/binarize_w1_luma_bin.sv
// Combinational luma threshold: gray = (77r + 150g + 29b) >> 8, output FF when gray >= threshold.
module luma_bin
    import qr_pkg::*;
(
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    input  logic [7:0] i_threshold,
    output logic [7:0] o_bin
);
    logic [15:0] w_sum;
    logic [15:0] w_shift;

    // Weights sum to 256, so the 16-bit accumulate tops out at 65280 and never wraps
    assign w_sum   = 16'(LUMA_R) * {8'd0, i_r}
                   + 16'(LUMA_G) * {8'd0, i_g}
                   + 16'(LUMA_B) * {8'd0, i_b};
    assign w_shift = w_sum >> LUMA_SHIFT;
    assign o_bin   = (w_shift[7:0] >= i_threshold) ? 8'hFF : 8'h00;
endmodule

// File: rtl/binarize_w1.sv
// In-place RGB->binary conversion of the frame RAM; 3 + (RD_LAT-1) + 1 + 3 cycles per pixel.
// No backpressure: the RAM port is owned while w1_work is high; dropping it aborts next cycle.
module binarize_w1
    import qr_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LAT     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          w1_work,
    output logic          w1_work_end,
    binarize_w1_if.master ram,
    input  logic [31:0]   width,
    input  logic [31:0]   height,
    input  logic [7:0]    threshold,
    output logic          w1_err
);
    state_t                r_state;
    state_t                w_next;
    logic                  r_work_d;
    logic [31:0]           r_npix;
    logic [31:0]           r_pix;
    logic [7:0]            r_thr;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [7:0]            r_cnt;
    cap_t                  r_pipe [RD_LAT];
    logic [7:0]            r_r, r_g, r_b, r_bin;
    logic                  r_err;

    logic                  w_start;
    logic                  w_abort;
    logic [31:0]           w_npix;
    logic                  w_oversize;
    logic                  w_last;
    logic                  w_b_now;
    logic [7:0]            w_b;
    logic [7:0]            w_bin;
    logic                  w_web;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_din;
    logic                  w_end;

    assign w_start    = (r_state == ST_IDLE) && w1_work && !r_work_d;
    assign w_abort    = (r_state != ST_IDLE) && !w1_work;
    assign w_npix     = width * height;
    assign w_oversize = ({2'b00, w_npix} * 34'd3) > (34'd1 << ADDR_WIDTH);
    assign w_last     = (r_pix == r_npix - 32'd1);

    // Blue lands on doutb during CMP itself, so it is taken straight from the bus
    assign w_b_now = r_pipe[RD_LAT-1].vld && (r_pipe[RD_LAT-1].idx == 2'd2);
    assign w_b     = w_b_now ? ram.doutb : r_b;

    luma_bin u_luma_bin (
        .i_r         (r_r),
        .i_g         (r_g),
        .i_b         (w_b),
        .i_threshold (r_thr),
        .o_bin       (w_bin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next = (w_oversize || w_npix == 32'd0) ? ST_DONE : ST_RD;
            ST_RD:   if (r_cnt == 8'd2) w_next = ST_WT;
            ST_WT:   if (r_cnt == 8'(RD_LAT - 2)) w_next = ST_CMP;
            ST_CMP:  w_next = ST_WR;
            ST_WR:   if (r_cnt == 8'd2) w_next = w_last ? ST_DONE : ST_RD;
            ST_DONE: w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
        if (w_abort) w_next = ST_IDLE;
    end

    always_comb begin
        w_web  = 1'b0;
        w_addr = '0;
        w_din  = 8'd0;
        w_end  = 1'b0;
        case (r_state)
            ST_RD: w_addr = r_base + ADDR_WIDTH'(r_cnt);
            ST_WR: begin
                w_web  = w1_work;
                w_addr = r_base + ADDR_WIDTH'(r_cnt);
                w_din  = r_bin;
            end
            ST_DONE: w_end = 1'b1;
            default: ;
        endcase
    end

    assign ram.web_w1   = w_web;
    assign ram.addrb_w1 = w_addr;
    assign ram.dinb_w1  = w_din;
    assign w1_work_end  = w_end;
    assign w1_err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work_d <= 1'b0;
            r_npix   <= 32'd0;
            r_pix    <= 32'd0;
            r_thr    <= 8'd0;
            r_base   <= '0;
            r_err    <= 1'b0;
            r_bin    <= 8'd0;
        end else begin
            r_work_d <= w1_work;
            if (w_start) begin
                r_npix <= w_npix;
                r_thr  <= threshold;
                r_pix  <= 32'd0;
                r_base <= '0;
                r_err  <= w_oversize;
            end else if (r_state == ST_WR && r_cnt == 8'd2 && w1_work && !w_last) begin
                r_pix  <= r_pix + 32'd1;
                r_base <= r_base + ADDR_WIDTH'(BYTES_PER_PIX);
            end
            if (r_state == ST_CMP) r_bin <= w_bin;
        end
    end

    // Capture line: a read issued in RD returns on doutb exactly RD_LAT cycles later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
            r_r <= 8'd0;
            r_g <= 8'd0;
            r_b <= 8'd0;
        end else if (w_abort) begin
            for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= '{vld: (r_state == ST_RD), idx: r_cnt[1:0]};
            for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            if (r_pipe[RD_LAT-1].vld) begin
                case (r_pipe[RD_LAT-1].idx)
                    2'd0:    r_r <= ram.doutb;
                    2'd1:    r_g <= ram.doutb;
                    default: r_b <= ram.doutb;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_binarize_w1.sv
// Directed bench: models solve_img's registered port-b mux plus a 1-cycle BRAM around binarize_w1.
module tb_binarize_w1;
    localparam int AW     = 18;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w1_work;
    logic        w1_work_end;
    logic        w1_err;
    logic [31:0] width, height;
    logic [7:0]  threshold;

    int checks = 0;
    int errors = 0;

    binarize_w1_if #(.ADDR_WIDTH(AW)) ram_if ();

    binarize_w1 #(.ADDR_WIDTH(AW), .RD_LAT(RD_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .w1_work     (w1_work),
        .w1_work_end (w1_work_end),
        .ram         (ram_if.master),
        .width       (width),
        .height      (height),
        .threshold   (threshold),
        .w1_err      (w1_err)
    );

    always #5 clk = ~clk;

    // RAM model: mux register stage, then read-first BRAM with registered output
    logic [7:0]    mem [64];
    logic [7:0]    img [64];
    logic          ld_req = 1'b0;
    logic          mux_we;
    logic [AW-1:0] mux_addr;
    logic [7:0]    mux_din;
    int            web_cnt = 0;
    int            acc_cnt = 0;
    int            overlap = 0;

    always @(posedge clk) begin
        mux_we   <= ram_if.web_w1;
        mux_addr <= ram_if.addrb_w1;
        mux_din  <= ram_if.dinb_w1;
        ram_if.doutb <= mem[mux_addr[5:0]];
        if (ld_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= img[i];
            web_cnt <= 0;
            acc_cnt <= 0;
        end else begin
            if (mux_we === 1'b1) mem[mux_addr[5:0]] <= mux_din;
            if (ram_if.web_w1) web_cnt <= web_cnt + 1;
            if (ram_if.web_w1 || ram_if.addrb_w1 != '0) acc_cnt <= acc_cnt + 1;
        end
    end

    always @(negedge clk) if (ram_if.web_w1 && w1_work_end) overlap++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_ram();
        ld_req = 1'b1;
        @(negedge clk);
        ld_req = 1'b0;
    endtask

    // Raise w1_work and count cycles until w1_work_end (w1_work is left high)
    task automatic run(input string tag, input int budget, output int n);
        w1_work = 1'b1;
        n = 0;
        while (!w1_work_end && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk({tag, "_timeout"}, 32'(n), 32'(budget - 1));
    endtask

    task automatic release_run();
        w1_work = 1'b0;
        tick(3);
    endtask

    initial begin
        int n;
        int bad;
        int wc;
        rst_n = 1'b0; w1_work = 1'b0;
        width = 32'd0; height = 32'd0; threshold = 8'd0;
        for (int i = 0; i < 64; i++) img[i] = 8'h5A;
        tick(2);
        chk("rst_end", {31'd0, w1_work_end}, 32'd0);
        chk("rst_web", {31'd0, ram_if.web_w1}, 32'd0);
        chk("rst_addr", 32'(ram_if.addrb_w1), 32'd0);
        chk("rst_din", {24'd0, ram_if.dinb_w1}, 32'd0);
        chk("rst_err", {31'd0, w1_err}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Basic: one white and one black pixel
        img[0] = 8'hFF; img[1] = 8'hFF; img[2] = 8'hFF;
        img[3] = 8'h00; img[4] = 8'h00; img[5] = 8'h00;
        load_ram();
        width = 32'd2; height = 32'd1; threshold = 8'd128;
        run("basic", 100, n);
        chk("basic_latency", 32'(n), 32'd17);
        tick(3);
        chk("basic_end_hold", {31'd0, w1_work_end}, 32'd1);
        chk("basic_web_in_done", {31'd0, ram_if.web_w1}, 32'd0);
        w1_work = 1'b0;
        tick(1);
        chk("basic_end_release", {31'd0, w1_work_end}, 32'd0);
        tick(2);
        bad = 0;
        for (int i = 0; i < 3; i++) if (mem[i] !== 8'hFF) bad++;
        for (int i = 3; i < 6; i++) if (mem[i] !== 8'h00) bad++;
        chk("basic_data", 32'(bad), 32'd0);
        chk("basic_untouched", {24'd0, mem[6]}, 32'h5A);
        chk("basic_web_count", 32'(web_cnt), 32'd6);

        // Threshold edge: (100,150,200) gives gray 140
        img[0] = 8'd100; img[1] = 8'd150; img[2] = 8'd200;
        load_ram();
        width = 32'd1; height = 32'd1; threshold = 8'd140;
        run("thr140", 50, n);
        chk("thr140_latency", 32'(n), 32'd9);
        release_run();
        chk("thr140_data", {8'd0, mem[0], mem[1], mem[2]}, 32'hFFFFFF);
        load_ram();
        threshold = 8'd141;
        run("thr141", 50, n);
        release_run();
        chk("thr141_data", {8'd0, mem[0], mem[1], mem[2]}, 32'h000000);

        // Oversize: 512*256*3 bytes exceeds 2**18
        load_ram();
        width = 32'd512; height = 32'd256;
        run("over", 10, n);
        chk("over_err", {31'd0, w1_err}, 32'd1);
        chk("over_end", {31'd0, w1_work_end}, 32'd1);
        release_run();
        chk("over_no_access", 32'(acc_cnt), 32'd0);

        // Zero size, which also clears the previous error
        load_ram();
        width = 32'd0; height = 32'd480;
        run("zero", 10, n);
        chk("zero_fast", {31'd0, n <= 2}, 32'd1);
        chk("zero_err", {31'd0, w1_err}, 32'd0);
        release_run();
        chk("zero_no_web", 32'(web_cnt), 32'd0);

        // Abort during WR of pixel 5, then restart from address 0
        for (int i = 0; i < 48; i++) img[i] = 8'h80;
        load_ram();
        width = 32'd4; height = 32'd4; threshold = 8'd200;
        w1_work = 1'b1;
        wc = 0;
        n = 0;
        while (wc < 17 && n < 300) begin
            @(negedge clk);
            n++;
            if (ram_if.web_w1) wc++;
        end
        chk("abort_reach_wr", 32'(wc), 32'd17);
        chk("abort_wr_addr", 32'(ram_if.addrb_w1), 32'd16);
        w1_work = 1'b0;
        #1;
        chk("abort_web_drop", {31'd0, ram_if.web_w1}, 32'd0);
        tick(1);
        chk("abort_idle_addr", 32'(ram_if.addrb_w1), 32'd0);
        chk("abort_idle_end", {31'd0, w1_work_end}, 32'd0);
        tick(3);
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 8'h00) bad++;
        for (int i = 16; i < 48; i++) if (mem[i] !== 8'h80) bad++;
        chk("abort_mem", 32'(bad), 32'd0);
        w1_work = 1'b1;
        @(negedge clk);
        chk("restart_addr0", 32'(ram_if.addrb_w1), 32'd0);
        n = 1;
        while (!w1_work_end && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("restart_latency", 32'(n), 32'd129);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (w1_work_end !== 1'b1) bad++;
        end
        chk("done_hold10", 32'(bad), 32'd0);
        w1_work = 1'b0;
        tick(1);
        chk("done_release", {31'd0, w1_work_end}, 32'd0);
        tick(2);
        bad = 0;
        for (int i = 0; i < 48; i++) if (mem[i] !== 8'h00) bad++;
        chk("restart_mem", 32'(bad), 32'd0);
        chk("no_web_in_done", 32'(overlap), 32'd0);

        // Asynchronous reset in the middle of RD
        width = 32'd2; height = 32'd1;
        w1_work = 1'b1;
        tick(2);
        chk("pre_rst_addr", 32'(ram_if.addrb_w1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(ram_if.addrb_w1), 32'd0);
        chk("mid_rst_ctl", {29'd0, w1_work_end, ram_if.web_w1, w1_err}, 32'd0);
        chk("mid_rst_din", {24'd0, ram_if.dinb_w1}, 32'd0);
        w1_work = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/binarize_w1.md
Name: binarize_w1

Overview:
- W1 worker stage driven by solve_img during its W1 phase.
- Converts the RGB image held in the shared frame RAM (3 bytes per pixel, R,G,B at consecutive addresses from 0) to a binary image in place, using luma weighting and a threshold.
- Writes 8'hFF or 8'h00 to all three bytes of each pixel, then signals completion.
- RAM access goes through solve_img's registered port-b mux.

Parameters:
- ADDR_WIDTH, 18, frame RAM address width.
- RD_LAT, 2, cycles from addrb_w1 driven to doutb valid (1 mux register plus 1 BRAM).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- w1_work  in  1  run request level from solve_img
- w1_work_end  out  1  done level
- web_w1  out  1  RAM write enable
- addrb_w1  out  ADDR_WIDTH  RAM address
- dinb_w1  out  8  RAM write data
- doutb  in  8  RAM read data
- width  in  32  image width in pixels
- height  in  32  image height in pixels
- threshold  in  8  binarization threshold
- w1_err  out  1  oversize flag

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: every output is 0. FSM is in IDLE.
- Start (IDLE, rising edge of w1_work detected):
  - Latch npix = width*height (32-bit, truncated) and threshold.
  - Clear pixel counter pix and base address base = 0.
- Zero size: npix == 0 -> go to DONE. No writes.
- Oversize: npix*3 > 2**ADDR_WIDTH (34-bit compare) -> set w1_err, go to DONE, no RAM access.
  - w1_err clears at the next start or at reset.
- States: IDLE, RD, WT, CMP, WR, DONE.
- RD, 3 cycles:
  - addrb_w1 = base, base+1, base+2; web_w1 = 0.
  - A 3-bit valid/index shift line of depth RD_LAT captures doutb into r, g, b exactly RD_LAT cycles after each issue.
- WT: wait until b is captured (RD_LAT-1 cycles after the last RD cycle), then go to CMP.
- CMP, 1 cycle:
  - gray = (77*r + 150*g + 29*b) >> 8, 16-bit accumulate (max 65280, no overflow).
  - bin = (gray >= threshold) ? 8'hFF : 8'h00.
- WR, 3 cycles:
  - web_w1 = 1, addrb_w1 = base..base+2, dinb_w1 = bin.
  - Then, if pix == npix-1 -> DONE; else pix += 1, base += 3, go to RD.
- Per-pixel cost: 3 + (RD_LAT-1) + 1 + 3 = 8 cycles at RD_LAT = 2.
- DONE:
  - web_w1 = 0 and w1_work_end = 1, held while w1_work = 1.
  - When w1_work = 0 -> IDLE with w1_work_end = 0 on the next cycle.
- Write-enable rule: web_w1 = 0 whenever w1_work_end = 1. solve_img holds its registered web one cycle after leaving W1, so a write must never be pending at handoff.
- Abort: w1_work falls in any non-IDLE state -> IDLE next cycle.
  - web_w1 forced 0 on that cycle.
  - In-flight read captures are discarded. No restart until a new rising edge.
- IDLE outputs: addrb_w1 = 0, dinb_w1 = 0, web_w1 = 0.
- w1_work already high on reset release counts as a rising edge.

Decomposition:
- Shared package qr_pkg:
  - State encoding localparams (IDLE..DONE).
  - Luma coefficients 77/150/29 and shift 8.
  - Byte-per-pixel constant 3.
- Sub-module luma_bin: combinational r,g,b,threshold -> bin, instantiated once in CMP.
- The FSM, counters and capture pipeline remain in binarize_w1.

Test Plan:
- Basic conversion: width=2, height=1, RAM[0..5] = FF,FF,FF,00,00,00, threshold=128 -> writes FF at 0,1,2 and 00 at 3,4,5. w1_work_end rises 17 cycles after start at RD_LAT=2. web_w1 = 0 while w1_work_end = 1.
- Threshold edge: pixel (100,150,200), gray = 140. threshold=140 -> FF×3; threshold=141 -> 00×3.
- Zero size: width=0, height=480 -> w1_work_end within 2 cycles, no web_w1 pulse, w1_err = 0.
- Oversize: ADDR_WIDTH=18, width=512, height=256 (393216 bytes > 262144) -> w1_err = 1, w1_work_end = 1, no RAM access.
- Abort and restart: width=4, height=4, drop w1_work during WR of pixel 5 -> web_w1 = 0 next cycle, FSM IDLE, pixels 6..15 unchanged. Re-raise w1_work -> full run from address 0.
- Handshake release and mid-run reset:
  - Hold w1_work high 10 cycles into DONE -> w1_work_end stays 1. Lower it -> w1_work_end = 0 next cycle.
  - Assert rst_n = 0 mid-RD -> all outputs 0 immediately (asynchronous).
